// File: rtl/axi_pkg.sv
// Shared AXI read-side types: address/data payload structs, response codes,
// ID widths and the read-arbiter state encoding.
package axi_pkg;

    localparam int AXI_ID_BITS  = 4;
    localparam int AXI_IDX_BITS = 4;
    localparam int AXI_IDS_BITS = AXI_IDX_BITS + AXI_ID_BITS;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        DECERR = 2'b11
    } RRESP;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } AddrInfo;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } DataInfo;

    localparam int AR_W = $bits(AddrInfo);
    localparam int R_W  = $bits(DataInfo);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } ArbState;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// searching cyclically. Shared by the read and write arbiters.
module rr_pick #(
    parameter int NUM_M = 2,
    parameter int PTR_W = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any
);

    logic [PTR_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the closest requester wins.
    always_comb begin
        gnt_idx = ptr;
        w_idx   = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            w_idx = PTR_W'((int'(ptr) + k) % NUM_M);
            if (req[w_idx]) begin
                gnt_idx = w_idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read slave port among NUM_M masters;
// one transaction in flight, grant held from AR handshake to the last R beat.
module axi_read_arbiter
    import axi_pkg::*;
#(
    parameter int NUM_M    = 2,
    parameter int IDX_BITS = AXI_IDS_BITS - AXI_ID_BITS
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [NUM_M*AXI_ID_BITS-1:0]    ARID_M,
    input  logic [NUM_M*AR_W-1:0]           AR_M,
    input  logic [NUM_M-1:0]                ARVALID_M,
    output logic [NUM_M-1:0]                ARREADY_M,
    output logic [NUM_M*AXI_ID_BITS-1:0]    RID_M,
    output logic [NUM_M*R_W-1:0]            R_M,
    output logic [NUM_M*2-1:0]              RRESP_M,
    output logic [NUM_M-1:0]                RVALID_M,
    input  logic [NUM_M-1:0]                RREADY_M,
    output logic [IDX_BITS+AXI_ID_BITS-1:0] ARID_S,
    output logic [AR_W-1:0]                 AR_S,
    output logic                            ARVALID_S,
    input  logic                            ARREADY_S,
    input  logic [IDX_BITS+AXI_ID_BITS-1:0] RID_S,
    input  logic [R_W-1:0]                  R_S,
    input  logic [1:0]                      RRESP_S,
    input  logic                            RVALID_S,
    output logic                            RREADY_S
);

    localparam int PTR_W = $clog2(NUM_M);

    ArbState                r_state;
    ArbState                w_state_next;
    logic [PTR_W-1:0]       r_grant;
    logic [PTR_W-1:0]       w_grant_next;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [PTR_W-1:0]       w_rr_ptr_next;
    logic [PTR_W-1:0]       w_pick;
    logic                   w_any;
    logic                   w_in_addr;
    logic                   w_in_data;
    logic [NUM_M-1:0]       w_sel;
    logic                   w_unused_rid;
    DataInfo                w_r_s;
    logic [AXI_ID_BITS-1:0] w_arid_m [NUM_M];
    logic [AR_W-1:0]        w_ar_m   [NUM_M];

    assign w_r_s = R_S;
    // R is routed by the latched grant; the index field of RID_S is not trusted.
    assign w_unused_rid = ^RID_S[IDX_BITS+AXI_ID_BITS-1:AXI_ID_BITS];

    rr_pick #(
        .NUM_M (NUM_M),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req     (ARVALID_M),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_pick),
        .any     (w_any)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_next;
            r_grant  <= w_grant_next;
            r_rr_ptr <= w_rr_ptr_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_grant_next  = r_grant;
        w_rr_ptr_next = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_next  = ADDR;
                    w_grant_next  = w_pick;
                    w_rr_ptr_next = (w_pick == PTR_W'(NUM_M - 1)) ? '0 : w_pick + 1'b1;
                end
            end
            ADDR: begin
                if (ARREADY_S) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (RVALID_S && RREADY_S && w_r_s.last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_in_addr = (r_state == ADDR);
        w_in_data = (r_state == DATA);
        ARVALID_S = w_in_addr;
        AR_S      = w_in_addr ? w_ar_m[r_grant] : '0;
        ARID_S    = w_in_addr ? {IDX_BITS'(r_grant), w_arid_m[r_grant]} : '0;
        RREADY_S  = w_in_data & RREADY_M[r_grant];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_M; gi++) begin : g_master
            assign w_arid_m[gi] = ARID_M[gi*AXI_ID_BITS +: AXI_ID_BITS];
            assign w_ar_m[gi]   = AR_M[gi*AR_W +: AR_W];
            assign w_sel[gi]    = (r_grant == PTR_W'(gi));

            assign ARREADY_M[gi] = w_in_addr & w_sel[gi] & ARREADY_S;
            assign RVALID_M[gi]  = w_in_data & w_sel[gi] & RVALID_S;
            assign R_M[gi*R_W +: R_W] = (w_in_data & w_sel[gi]) ? w_r_s : '0;
            assign RRESP_M[gi*2 +: 2] = (w_in_data & w_sel[gi]) ? RRESP_S : 2'b00;
            assign RID_M[gi*AXI_ID_BITS +: AXI_ID_BITS] =
                (w_in_data & w_sel[gi]) ? RID_S[AXI_ID_BITS-1:0] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: cycle table for reset, arbitration,
// fairness, error codes and mid-transaction reset, plus a backpressured burst.
module tb_axi_read_arbiter;
    import axi_pkg::*;

    localparam int NM = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NM*AXI_ID_BITS-1:0] ARID_M;
    logic [NM*AR_W-1:0]        AR_M;
    logic [NM-1:0]             ARVALID_M;
    logic [NM-1:0]             ARREADY_M;
    logic [NM*AXI_ID_BITS-1:0] RID_M;
    logic [NM*R_W-1:0]         R_M;
    logic [NM*2-1:0]           RRESP_M;
    logic [NM-1:0]             RVALID_M;
    logic [NM-1:0]             RREADY_M;
    logic [AXI_IDS_BITS-1:0]   ARID_S;
    logic [AR_W-1:0]           AR_S;
    logic                      ARVALID_S;
    logic                      ARREADY_S;
    logic [AXI_IDS_BITS-1:0]   RID_S;
    logic [R_W-1:0]            R_S;
    logic [1:0]                RRESP_S;
    logic                      RVALID_S;
    logic                      RREADY_S;

    always #5 clk = ~clk;

    axi_read_arbiter #(
        .NUM_M    (NM),
        .IDX_BITS (4)
    ) dut (
        .ACLK      (clk),
        .ARESET    (rst),
        .ARID_M    (ARID_M),
        .AR_M      (AR_M),
        .ARVALID_M (ARVALID_M),
        .ARREADY_M (ARREADY_M),
        .RID_M     (RID_M),
        .R_M       (R_M),
        .RRESP_M   (RRESP_M),
        .RVALID_M  (RVALID_M),
        .RREADY_M  (RREADY_M),
        .ARID_S    (ARID_S),
        .AR_S      (AR_S),
        .ARVALID_S (ARVALID_S),
        .ARREADY_S (ARREADY_S),
        .RID_S     (RID_S),
        .R_S       (R_S),
        .RRESP_S   (RRESP_S),
        .RVALID_S  (RVALID_S),
        .RREADY_S  (RREADY_S)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  arv;
        logic        ars;
        logic        rvs;
        logic [1:0]  rrm;
        logic        last;
        logic [1:0]  resp;
        logic [17:0] exp;   // {ARVALID_S, ARREADY_M, RVALID_M, RREADY_S, ARID_S, RRESP_M}
    } vec_t;

    vec_t    vecs[$];
    int      n_vec = 0;
    int      n_bad = 0;
    AddrInfo ar0 = '{addr: 32'h0000_1000, len: 8'd0, size: 3'd2, burst: 2'b01};
    AddrInfo ar1 = '{addr: 32'h0000_2000, len: 8'd3, size: 3'd2, burst: 2'b01};

    logic        b_rvs [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        b_rdy [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        b_lst [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] b_dat [7] = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0001, 32'h0,
                               32'hD000_0002, 32'hD000_0003, 32'hD000_0003};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] arv, input logic ars, input logic rvs,
                         input logic [1:0] rrm, input logic [31:0] d, input logic last,
                         input logic [1:0] resp);
        rst       = r;
        ARVALID_M = arv;
        ARREADY_S = ars;
        RVALID_S  = rvs;
        RREADY_M  = rrm;
        R_S       = {d, last};
        RRESP_S   = resp;
    endtask

    task automatic addv(input logic r, input logic [1:0] arv, input logic ars, input logic rvs,
                        input logic [1:0] rrm, input logic last, input logic [1:0] resp,
                        input logic e_arvs, input logic [1:0] e_arrm, input logic [1:0] e_rvm,
                        input logic e_rrs, input logic [7:0] e_arid, input logic [3:0] e_resp);
        vec_t v;
        v.rst  = r;
        v.arv  = arv;
        v.ars  = ars;
        v.rvs  = rvs;
        v.rrm  = rrm;
        v.last = last;
        v.resp = resp;
        v.exp  = {e_arvs, e_arrm, e_rvm, e_rrs, e_arid, e_resp};
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
        $fatal(1);
    end

    initial begin
        logic [17:0] act;
        drive(1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 2'b00);
        ARID_M = {4'h3, 4'h5};
        AR_M   = {ar1, ar0};
        RID_S  = 8'h00;

        // reset with both requesting, then master 0 first
        addv(1, 2'b11, 0, 1, 2'b11, 1, 2'b11,  0, 2'b00, 2'b00, 0, 8'h00, 4'h0);
        addv(1, 2'b11, 0, 1, 2'b11, 1, 2'b11,  0, 2'b00, 2'b00, 0, 8'h00, 4'h0);
        addv(0, 2'b11, 0, 0, 2'b00, 0, 2'b00,  0, 2'b00, 2'b00, 0, 8'h00, 4'h0);
        addv(0, 2'b11, 0, 0, 2'b00, 0, 2'b00,  1, 2'b00, 2'b00, 0, 8'h05, 4'h0);
        addv(0, 2'b11, 1, 0, 2'b00, 0, 2'b00,  1, 2'b01, 2'b00, 0, 8'h05, 4'h0);
        addv(0, 2'b11, 1, 1, 2'b11, 0, 2'b00,  0, 2'b00, 2'b01, 1, 8'h00, 4'h0);
        addv(0, 2'b11, 0, 1, 2'b11, 1, 2'b11,  0, 2'b00, 2'b01, 1, 8'h00, 4'h3);
        // contention: alternation 1, 0, 1 with a one-cycle slave latency
        addv(0, 2'b11, 1, 0, 2'b11, 0, 2'b00,  0, 2'b00, 2'b00, 0, 8'h00, 4'h0);
        addv(0, 2'b11, 1, 0, 2'b11, 0, 2'b00,  1, 2'b10, 2'b00, 0, 8'h13, 4'h0);
        addv(0, 2'b11, 1, 0, 2'b11, 0, 2'b00,  0, 2'b00, 2'b00, 1, 8'h00, 4'h0);
        addv(0, 2'b11, 1, 1, 2'b11, 1, 2'b00,  0, 2'b00, 2'b10, 1, 8'h00, 4'h0);
        addv(0, 2'b11, 1, 0, 2'b11, 0, 2'b00,  0, 2'b00, 2'b00, 0, 8'h00, 4'h0);
        addv(0, 2'b11, 1, 0, 2'b11, 0, 2'b00,  1, 2'b01, 2'b00, 0, 8'h05, 4'h0);
        addv(0, 2'b11, 1, 0, 2'b11, 0, 2'b00,  0, 2'b00, 2'b00, 1, 8'h00, 4'h0);
        addv(0, 2'b11, 1, 1, 2'b11, 1, 2'b00,  0, 2'b00, 2'b01, 1, 8'h00, 4'h0);
        addv(0, 2'b11, 1, 0, 2'b11, 0, 2'b00,  0, 2'b00, 2'b00, 0, 8'h00, 4'h0);
        addv(0, 2'b11, 1, 0, 2'b11, 0, 2'b00,  1, 2'b10, 2'b00, 0, 8'h13, 4'h0);
        addv(0, 2'b11, 1, 1, 2'b01, 1, 2'b10,  0, 2'b00, 2'b10, 0, 8'h00, 4'h8);
        addv(0, 2'b11, 1, 1, 2'b10, 1, 2'b10,  0, 2'b00, 2'b10, 1, 8'h00, 4'h8);
        // idle, lone request, late request ignored, then reset mid-DATA
        addv(0, 2'b00, 0, 0, 2'b00, 0, 2'b00,  0, 2'b00, 2'b00, 0, 8'h00, 4'h0);
        addv(0, 2'b01, 0, 0, 2'b00, 0, 2'b00,  0, 2'b00, 2'b00, 0, 8'h00, 4'h0);
        addv(0, 2'b11, 0, 0, 2'b00, 0, 2'b00,  1, 2'b00, 2'b00, 0, 8'h05, 4'h0);
        addv(0, 2'b01, 1, 0, 2'b00, 0, 2'b00,  1, 2'b01, 2'b00, 0, 8'h05, 4'h0);
        addv(0, 2'b00, 0, 1, 2'b01, 0, 2'b00,  0, 2'b00, 2'b01, 1, 8'h00, 4'h0);
        addv(0, 2'b00, 0, 1, 2'b01, 0, 2'b00,  0, 2'b00, 2'b01, 1, 8'h00, 4'h0);
        addv(1, 2'b11, 0, 1, 2'b01, 0, 2'b00,  0, 2'b00, 2'b01, 1, 8'h00, 4'h0);
        addv(0, 2'b11, 0, 1, 2'b11, 1, 2'b00,  0, 2'b00, 2'b00, 0, 8'h00, 4'h0);
        addv(0, 2'b11, 0, 0, 2'b00, 0, 2'b00,  1, 2'b00, 2'b00, 0, 8'h05, 4'h0);

        @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].arv, vecs[i].ars, vecs[i].rvs, vecs[i].rrm,
                  32'hA5A5_0000 + 32'(i), vecs[i].last, vecs[i].resp);
            #2;
            act = {ARVALID_S, ARREADY_M, RVALID_M, RREADY_S, ARID_S, RRESP_M};
            $display("vec %0d: rst=%b arv=%b -> %h (want %h)", i, vecs[i].rst, vecs[i].arv,
                     act, vecs[i].exp);
            chk($sformatf("vec%0d", i), 128'(act), 128'(vecs[i].exp));
        end

        // master 1 burst of 4 with AR stall and R backpressure; RID_S index field wrong
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 2'b00);
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 2'b00);
        RID_S = 8'h03;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            #2;
            $display("ar wait %0d: ARID_S=%h AR_S=%h", w, ARID_S, AR_S);
            chk("ar_wait_ar_s", 128'(AR_S), 128'(ar1));
            chk("ar_wait_arid", 128'(ARID_S), 128'(8'h13));
            chk("ar_wait_arready", 128'({ARVALID_S, ARREADY_M}), 128'(3'b100));
        end
        @(negedge clk);
        ARREADY_S = 1'b1;
        #2;
        chk("ar_accept", 128'({ARVALID_S, ARREADY_M}), 128'(3'b110));

        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            drive(1'b0, 2'b00, 1'b0, b_rvs[k], {b_rdy[k], 1'b0}, b_dat[k], b_lst[k], 2'b00);
            #2;
            $display("beat %0d: RVALID_M=%b RREADY_S=%b R_M=%h", k, RVALID_M, RREADY_S, R_M);
            chk($sformatf("beat%0d_rvalid", k), 128'(RVALID_M), 128'({b_rvs[k], 1'b0}));
            chk($sformatf("beat%0d_rready_s", k), 128'(RREADY_S), 128'(b_rdy[k]));
            chk($sformatf("beat%0d_r_m", k), 128'(R_M), 128'({b_dat[k], b_lst[k], 33'b0}));
            chk($sformatf("beat%0d_rid_m", k), 128'(RID_M), 128'(8'h30));
        end

        @(negedge clk);
        drive(1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 32'hEEEE_EEEE, 1'b1, 2'b00);
        #2;
        $display("after last: ARVALID_S=%b RVALID_M=%b RREADY_S=%b", ARVALID_S, RVALID_M, RREADY_S);
        chk("post_last_idle", 128'({ARVALID_S, RVALID_M, RREADY_S}), 128'(4'b0000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Round-robin arbiter that shares one AXI read-address/read-data slave port among `NUM_M` read masters, such as CPU instruction fetch and data load. It sits between the masters and the read side of the bus decoder, in front of memory slaves and the default slave.
- One read transaction is outstanding at a time.
- The grant is held from the AR handshake until the last R beat completes.
- Returned IDs are widened with the master index.

## Interface
Parameters:
- `NUM_M`, 2: number of requesting masters, 2..4.
- `IDX_BITS`, 4: master-index field prepended to the ID, so `AXI_IDS_BITS` = `IDX_BITS` + `AXI_ID_BITS`.

Ports (`AR_W` = `$bits(AddrInfo)`, `R_W` = `$bits(DataInfo)`):
- `ACLK`  in  1  clock; single clock domain.
- `ARESET`  in  1  reset, synchronous, active-high.
- `ARID_M`  in  `NUM_M`×`AXI_ID_BITS`  per-master read ID.
- `AR_M`  in  `NUM_M`×`AR_W`  per-master packed `AddrInfo`.
- `ARVALID_M`  in  `NUM_M`  per-master request.
- `ARREADY_M`  out  `NUM_M`  per-master accept.
- `RID_M`  out  `NUM_M`×`AXI_ID_BITS`  returned ID, low bits of `RID_S`.
- `R_M`  out  `NUM_M`×`R_W`  packed `DataInfo` (data, last).
- `RRESP_M`  out  `NUM_M`×2  response code.
- `RVALID_M`  out  `NUM_M`  read-data valid.
- `RREADY_M`  in  `NUM_M`  read-data ready.
- `ARID_S`  out  `AXI_IDS_BITS`  {grant index, `ARID_M`[grant]}.
- `AR_S`  out  `AR_W`  `AR_M`[grant].
- `ARVALID_S`  out  1  request to slave side.
- `ARREADY_S`  in  1  slave accept.
- `RID_S`  in  `AXI_IDS_BITS`  slave read ID.
- `R_S`  in  `R_W`  slave read data.
- `RRESP_S`  in  2  slave response.
- `RVALID_S`  in  1  slave data valid.
- `RREADY_S`  out  1  ready to slave.

## Operation
- States: `IDLE`, `ADDR`, `DATA`. State, `grant` and the round-robin pointer `rr_ptr` are the only registers.
- `IDLE`
  - If any `ARVALID_M` is high, the arbiter registers `grant` = the first requesting master at or after `rr_ptr`, searching cyclically, and moves to `ADDR`.
  - The arbiter also sets `rr_ptr` = `grant`+1 mod `NUM_M`.
- `ADDR`
  - `ARVALID_S` = 1.
  - `AR_S` and `ARID_S` are driven combinationally from the granted master.
  - `ARREADY_M`[grant] = `ARREADY_S`.
  - When `ARVALID_S` and `ARREADY_S` are both high, the arbiter moves to `DATA`.
- `DATA`
  - `RVALID_M`[grant] = `RVALID_S` and `RREADY_S` = `RREADY_M`[grant].
  - `R_M`, `RRESP_M` and `RID_M` pass through for `grant`.
  - When `RVALID_S`, `RREADY_S` and `R_S.last` are all high, the arbiter returns to `IDLE`.
- Non-granted masters see `ARREADY_M` = 0 and `RVALID_M` = 0 in every state. `R_M` and `RID_M` of non-granted masters are don't-care and driven 0.
- R routing uses the latched `grant`, not `RID_S`. An `RID_S` upper field that differs from `grant` is a protocol error and is still routed to `grant`.
- `DECERR` (2'b11) and every other `RRESP_S` code pass through unchanged.
- If `ARVALID_M`[grant] drops in `ADDR` (an AXI violation), the arbiter stays in `ADDR` and keeps `ARVALID_S` high. No recovery is defined.

## Timing
- Reset, sampled on a `ACLK` rising edge:
  - state = `IDLE`, `grant` = 0, `rr_ptr` = 0.
  - All `ARREADY_M`, `RVALID_M`, `ARVALID_S` and `RREADY_S` = 0.
  - `AR_S`, `ARID_S`, `R_M`, `RID_M` and `RRESP_M` = 0.
- Reset mid-transaction abandons the transaction. The slave side is reset by the same `ARESET`.
- Latency:
  - The arbitration decision takes 1 cycle: request seen in `IDLE` at edge N, `ARVALID_S` high in cycle N+1.
  - Zero added latency on AR accept and on R beats (combinational passthrough).
- Minimum request-to-request spacing is 1 idle cycle after the last R beat.
- Simultaneous requests are resolved by `rr_ptr`. A requester that is not granted keeps `ARVALID_M` high and is served in a later `IDLE`.
- A new `ARVALID_M` arriving in `ADDR` or `DATA` is ignored until `IDLE`.

## Structure
- Shared package `axi_pkg`:
  - `AddrInfo`, `DataInfo`, the `RRESP` enum (`OKAY` and `DECERR`), and `AXI_ID_BITS` / `AXI_IDS_BITS`.
  - The arbiter state enum `ArbState` {`IDLE`, `ADDR`, `DATA`}.
- One sub-module, `rr_pick`: combinational round-robin selector with inputs `req`[`NUM_M`] and `ptr`, and outputs `gnt_idx` and `any`. It is reused by a later write arbiter.

## Test plan
1. Reset:
   - Stimulus: `ARESET` held high for 2 cycles with `ARVALID_M` = 2'b11.
   - Required: all outputs 0 and `ARVALID_S` = 0. After release, master 0 is granted first.
2. Single burst:
   - Stimulus: master 1 requests with `ARID` 4'h3 and len 3.
   - Required: `ARID_S` = 8'h13. Four beats reach `RVALID_M`[1] only. Return to `IDLE` on the beat with last = 1.
3. Contention and fairness:
   - Stimulus: both masters request continuously, len 0 each.
   - Required: grants alternate 0, 1, 0, 1, and each transaction takes 4 cycles with `ARREADY_S` = `RREADY` = 1.
4. Backpressure:
   - Stimulus: `ARREADY_S` low for 3 cycles, then `RREADY_M` toggled.
   - Required: `AR_S` stable during the wait, no beat lost, `RREADY_S` mirrors `RREADY_M`[grant].
5. Decode error:
   - Stimulus: slave returns `RRESP` = `DECERR` with last = 1 for a len-0 read.
   - Required: `RRESP_M`[grant] = 2'b11, then the arbiter returns to `IDLE`.
6. Reset mid-`DATA`:
   - Stimulus: assert `ARESET` after beat 2 of 4.
   - Required: next cycle state = `IDLE`, all valids 0, `rr_ptr` = 0.
